// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data access.
// Data has priority; a starvation counter forces fetch progress and a watchdog flags a hung RAM.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
    logic [31:0]   iload_q, iload_d;
    logic [31:0]   dload_q, dload_d;

    logic dreq;
    logic tmo_hit;
    logic starve_room;

    assign dreq        = dREN | dWEN;
    assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign starve_room = (starve_cnt_q < SW'(STARVE_MAX));
    assign err         = err_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
        iload_d      = iload_q;
        dload_d      = dload_q;
        iload        = iload_q;
        dload        = dload_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = 32'h0;
        ramstore     = 32'h0;

        case (state_q)
            IDLE: begin
                if (!iREN) begin
                    starve_cnt_d = '0;
                end
                if (dreq && (!iREN || starve_room)) begin
                    state_d   = DGNT;
                    tmo_cnt_d = '0;
                end else if (iREN) begin
                    state_d      = IGNT;
                    tmo_cnt_d    = '0;
                    starve_cnt_d = '0;
                end
            end

            IGNT: begin
                // Strobe drops in the same cycle the requester abandons the fetch.
                ramREN  = iREN | ram_ready;
                ramaddr = iaddr;
                if (ram_ready) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    iload_d = ramload;
                    state_d = IDLE;
                end else if (!iREN) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            DGNT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = dREN | ram_ready;
                end
                if (ram_ready) begin
                    dwait = 1'b0;
                    if (!dWEN) begin
                        dload   = ramload;
                        dload_d = ramload;
                    end
                    if (iREN && starve_room) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                    state_d = IDLE;
                end else if (!dreq) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // A reset cycle never completes a transaction nor drives the RAM.
        if (RST) begin
            iload    = iload_q;
            dload    = dload_q;
            iwait    = 1'b1;
            dwait    = 1'b1;
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = 32'h0;
            ramstore = 32'h0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
            iload_q      <= 32'h0;
            dload_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
            iload_q      <= iload_d;
            dload_q      <= dload_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: priority, starvation, writes, timeout, abort and reset.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int d_cnt;
        int seen_i;
        int after_kind;
        int gnt_cnt;
        int iw_low;

        RST = 1'b1; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ram_ready = 1'b0;
        cyc(); cyc();
        @(negedge CLK);
        chk("rst_iwait", {31'h0, iwait}, 32'h1);
        chk("rst_dwait", {31'h0, dwait}, 32'h1);
        chk("rst_ramREN", {31'h0, ramREN}, 32'h0);
        chk("rst_ramWEN", {31'h0, ramWEN}, 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        $display("txn reset: done");

        // 1: single instruction fetch, ready one cycle after the grant
        cyc();
        RST = 1'b0; iREN = 1'b1; iaddr = 32'h100;
        @(negedge CLK);
        chk("t1_idle_ramREN", {31'h0, ramREN}, 32'h0);
        cyc();
        @(negedge CLK);
        chk("t1_gnt_ramREN", {31'h0, ramREN}, 32'h1);
        chk("t1_gnt_ramaddr", ramaddr, 32'h100);
        chk("t1_gnt_iwait", {31'h0, iwait}, 32'h1);
        cyc();
        ram_ready = 1'b1; ramload = 32'h2408000A;
        @(negedge CLK);
        chk("t1_done_iwait", {31'h0, iwait}, 32'h0);
        chk("t1_done_iload", iload, 32'h2408000A);
        chk("t1_done_dwait", {31'h0, dwait}, 32'h1);
        cyc();
        ram_ready = 1'b0; iREN = 1'b0; ramload = 32'h0;
        @(negedge CLK);
        chk("t1_after_iwait", {31'h0, iwait}, 32'h1);
        chk("t1_after_ramREN", {31'h0, ramREN}, 32'h0);
        chk("t1_hold_iload", iload, 32'h2408000A);
        $display("txn ifetch addr=100 iload=%h", iload);

        // 2: simultaneous requests, data first, one idle cycle between
        cyc();
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h3F0;
        cyc();
        @(negedge CLK);
        chk("t2_d_ramaddr", ramaddr, 32'h3F0);
        chk("t2_d_ramREN", {31'h0, ramREN}, 32'h1);
        cyc();
        ram_ready = 1'b1; ramload = 32'h11111111;
        @(negedge CLK);
        chk("t2_d_dwait", {31'h0, dwait}, 32'h0);
        chk("t2_d_dload", dload, 32'h11111111);
        chk("t2_d_iwait", {31'h0, iwait}, 32'h1);
        cyc();
        ram_ready = 1'b0; dREN = 1'b0;
        @(negedge CLK);
        chk("t2_idle_ramREN", {31'h0, ramREN}, 32'h0);
        cyc();
        @(negedge CLK);
        chk("t2_i_ramaddr", ramaddr, 32'h200);
        chk("t2_i_ramREN", {31'h0, ramREN}, 32'h1);
        cyc();
        ram_ready = 1'b1; ramload = 32'h22222222;
        @(negedge CLK);
        chk("t2_i_iwait", {31'h0, iwait}, 32'h0);
        chk("t2_i_iload", iload, 32'h22222222);
        cyc();
        ram_ready = 1'b0; iREN = 1'b0;
        $display("txn d-then-i dload=%h iload=%h", dload, iload);

        // 3: continuous writes starve fetch for at most STARVE_MAX grants
        cyc();
        iREN = 1'b1; iaddr = 32'h300; dWEN = 1'b1; daddr = 32'h44; dstore = 32'h5;
        ram_ready = 1'b1; ramload = 32'h33333333;
        d_cnt = 0; seen_i = 0; after_kind = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            @(negedge CLK);
            if (!dwait) begin
                if (seen_i == 0) d_cnt++;
                else if (after_kind == 0) after_kind = 2;
            end
            if (!iwait) begin
                if (seen_i == 0) begin
                    seen_i = 1;
                    chk("t3_i_ramaddr", ramaddr, 32'h300);
                    chk("t3_i_dwait", {31'h0, dwait}, 32'h1);
                end else if (after_kind == 0) begin
                    after_kind = 1;
                end
            end
            if (after_kind != 0) break;
        end
        iREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        chk("t3_seen_ifetch", seen_i, 1);
        chk("t3_d_before_i", d_cnt, 4);
        chk("t3_next_is_data", after_kind, 2);
        $display("txn starvation data_grants=%0d", d_cnt);

        // 4: write wins over read when both are high
        cyc();
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        cyc();
        @(negedge CLK);
        chk("t4_ramWEN", {31'h0, ramWEN}, 32'h1);
        chk("t4_ramREN", {31'h0, ramREN}, 32'h0);
        chk("t4_ramstore", ramstore, 32'hDEADBEEF);
        chk("t4_ramaddr", ramaddr, 32'h80);
        chk("t4_wait_dwait", {31'h0, dwait}, 32'h1);
        cyc();
        ram_ready = 1'b1;
        @(negedge CLK);
        chk("t4_dwait", {31'h0, dwait}, 32'h0);
        cyc();
        ram_ready = 1'b0; dWEN = 1'b0; dREN = 1'b0;
        $display("txn write addr=80 data=deadbeef");

        // 5: hung RAM on an instruction grant
        cyc();
        iREN = 1'b1; iaddr = 32'h500;
        gnt_cnt = 0; iw_low = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            @(negedge CLK);
            if (err) break;
            if (ramREN) gnt_cnt++;
            if (!iwait) iw_low++;
        end
        chk("t5_err", {31'h0, err}, 32'h1);
        chk("t5_granted_cycles", gnt_cnt, 64);
        chk("t5_no_iwait_low", iw_low, 0);
        chk("t5_ramREN_low", {31'h0, ramREN}, 32'h0);
        chk("t5_iwait_high", {31'h0, iwait}, 32'h1);
        iREN = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge CLK);
        chk("t5_err_sticky", {31'h0, err}, 32'h1);
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        chk("t5_err_cleared", {31'h0, err}, 32'h0);
        $display("txn timeout granted_cycles=%0d", gnt_cnt);

        // 6a: data requester drops mid-grant
        cyc();
        dREN = 1'b1; daddr = 32'h60;
        cyc();
        @(negedge CLK);
        chk("t6a_gnt_ramREN", {31'h0, ramREN}, 32'h1);
        cyc();
        dREN = 1'b0;
        @(negedge CLK);
        chk("t6a_drop_ramREN", {31'h0, ramREN}, 32'h0);
        chk("t6a_drop_dwait", {31'h0, dwait}, 32'h1);
        cyc();
        ram_ready = 1'b1;
        @(negedge CLK);
        chk("t6a_idle_dwait", {31'h0, dwait}, 32'h1);
        chk("t6a_idle_ramREN", {31'h0, ramREN}, 32'h0);
        chk("t6a_err", {31'h0, err}, 32'h0);
        cyc();
        ram_ready = 1'b0;
        $display("txn abort addr=60");

        // 6b: reset mid-grant
        cyc();
        dREN = 1'b1; daddr = 32'h64;
        cyc();
        @(negedge CLK);
        chk("t6b_gnt_ramREN", {31'h0, ramREN}, 32'h1);
        cyc();
        RST = 1'b1; ram_ready = 1'b1;
        @(negedge CLK);
        chk("t6b_rst_dwait", {31'h0, dwait}, 32'h1);
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        chk("t6b_idle_dwait", {31'h0, dwait}, 32'h1);
        chk("t6b_idle_ramREN", {31'h0, ramREN}, 32'h0);
        chk("t6b_err", {31'h0, err}, 32'h0);
        dREN = 1'b0; ram_ready = 1'b0;
        cyc();
        $display("txn reset-mid-grant addr=64");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported RAM between the instruction-fetch path (icache/IF) and the data path (dcache/MEM) of the pipelined CPU.
- Sequences one RAM transaction at a time and returns data and wait status to the granted requester.
- The hazard unit's stage-enable terms (ihit/dhit) are derived from this block's iwait/dwait.
- The default policy gives the data path priority. A starvation counter guarantees instruction fetch progress. A timeout watchdog flags a hung RAM.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while an instruction request is pending, before instruction fetch is forced.
- TIMEOUT, 64: cycles a granted transaction may wait for ram_ready before it is aborted and err is set.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iload  out  32  instruction read data.
- iwait  out  1  low only in the completion cycle of an instruction read.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; takes precedence over dREN if both are high.
- daddr  in  32  data address.
- dstore  in  32  data write data.
- dload  out  32  data read data.
- dwait  out  1  low only in the completion cycle of a data access.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ram_ready  in  1  RAM access complete this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- One clock domain. RST is synchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0, tmo_cnt=0, err=0. iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- States: IDLE, IGNT, DGNT.
- IDLE:
  - Drives no RAM strobes.
  - If there is a data request (dREN|dWEN) and either iREN=0 or starve_cnt<STARVE_MAX, go to DGNT.
  - Else if iREN, go to IGNT.
  - Else stay in IDLE.
- Grant is registered. A request sampled in IDLE at cycle N drives the RAM from cycle N+1.
- IGNT:
  - ramREN=1, ramaddr=iaddr, ramWEN=0.
  - On ram_ready: iload=ramload and iwait=0 combinationally in the same cycle, then go to IDLE.
  - dwait stays 1.
- DGNT:
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. Otherwise ramREN=1.
  - ramaddr=daddr.
  - On ram_ready: dload=ramload (read) and dwait=0 in the same cycle, then go to IDLE.
  - iwait stays 1.
- Minimum latency is 2 cycles from request to completion (ram_ready in the first granted cycle). Back-to-back transactions each pass through IDLE for one cycle.
- Transactions are atomic. A grant is held until ram_ready, timeout, abort, or reset, and it is never preempted by the other requester.
- Abort: if the granted requester deasserts its request while ram_ready=0, go to IDLE next cycle. No completion pulse, err unchanged, strobes drop that same cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each DGNT completion while iREN=1.
  - Clears on IGNT entry, or when iREN=0 in IDLE.
- tmo_cnt:
  - Clears on grant entry and increments each granted cycle without ram_ready.
  - When tmo_cnt reaches TIMEOUT-1 without ram_ready: set err (sticky until RST), deassert strobes, go to IDLE, and do not lower the wait outputs.
- Simultaneous ram_ready and requester drop in the same cycle: the completion is honoured.
- RST mid-transaction: the state returns to IDLE on the next edge, strobes go low, and no completion pulse is issued.
- iload and dload hold their last value when not completing. Consumers must sample only when the corresponding wait is low.

Test Plan:
1. RST, then iREN=1, iaddr=0x100, ram_ready raised the cycle after the grant with ramload=0x2408000A. Required: ramREN=1, ramaddr=0x100, iwait=0 for exactly 1 cycle, iload=0x2408000A.
2. iREN=1 and dREN=1 asserted together at 0x200/0x3F0, ram_ready after 1 cycle each. Required: data served first (ramaddr=0x3F0), then instruction (ramaddr=0x200), with one IDLE cycle between.
3. iREN held high, dWEN pulsed continuously, STARVE_MAX=4. Required: exactly 4 data completions, then an instruction grant; the 5th data request waits for it.
4. dWEN=1 and dREN=1 with dstore=0xDEADBEEF, daddr=0x80. Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dwait=0 on ram_ready.
5. Granted iREN with ram_ready never asserted, TIMEOUT=64. Required: err=1 after 64 granted cycles, strobes low, iwait stays 1, err held until RST.
6. Data grant in progress, dREN dropped before ram_ready, and separately RST asserted mid-grant. Required: IDLE next cycle, no dwait low pulse, ramREN=0, err=0.
